// File: rtl/demod_integrate_pack.sv
// Integrate-and-dump bit slicer for the demodulator: sums SAMPLES_PER_BIT samples,
// thresholds against the amplitude captured on the first sample, and packs bits LSB-first.
module demod_integrate_pack #(
  parameter int unsigned SAMPLES_PER_BIT = 8,
  parameter int unsigned BITS_PER_WORD   = 32,
  parameter int unsigned ACC_W           = 35
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] demodulated_in,
  input  logic [31:0] a_in,
  input  logic        sync_clear,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        overrun
);

  localparam int unsigned SampCntW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int unsigned BitCntW  = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam logic [SampCntW-1:0] SampLast = SampCntW'(SAMPLES_PER_BIT - 1);
  localparam logic [BitCntW-1:0]  BitLast  = BitCntW'(BITS_PER_WORD - 1);

  typedef enum logic [0:0] {StAccum, StWait} state_e;

  state_e              state_q, state_d;
  logic                run_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    thr_q, thr_d;
  logic [SampCntW-1:0] samp_cnt_q, samp_cnt_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0]         shift_q, shift_d;
  logic [31:0]         pend_q, pend_d;
  logic [31:0]         word_q, word_d;
  logic                word_valid_q, word_valid_d;
  logic                overrun_q, overrun_d;

  logic [ACC_W-1:0] din_ext;
  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] sum;
  logic             bit_dec;
  logic [31:0]      shift_ins;
  logic             accept;
  logic             drain;
  logic             flush;
  logic             last_sample;
  logic             last_bit;
  logic             word_done;

  assign din_ext     = {{(ACC_W - 32){demodulated_in[31]}}, demodulated_in};
  assign a_ext       = {{(ACC_W - 32){a_in[31]}}, a_in};
  assign sum         = acc_q + din_ext;
  assign bit_dec     = $signed(sum) > $signed(thr_q);
  assign shift_ins   = shift_q | (32'(bit_dec) << bit_cnt_q);
  assign accept      = in_valid & in_ready;
  assign drain       = word_valid_q & word_ready;
  // sync_clear is ignored while waiting for the pending word to drain.
  assign flush       = sync_clear & (state_q == StAccum);
  assign last_sample = (samp_cnt_q == SampLast);
  assign last_bit    = (bit_cnt_q == BitLast);
  assign word_done   = accept & ~sync_clear & last_sample & last_bit;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (word_done && word_valid_q && !drain) state_d = StWait;
      StWait:  if (drain) state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  // Output logic; run_q keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready = run_q && (state_q == StAccum);
  end

  // Datapath next-state
  always_comb begin
    acc_d        = acc_q;
    thr_d        = thr_q;
    samp_cnt_d   = samp_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    pend_d       = pend_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;

    if (flush) begin
      acc_d      = '0;
      samp_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = '0;
    end else if (accept) begin
      if (samp_cnt_q == '0) begin
        acc_d = din_ext;
        thr_d = a_ext;
      end else begin
        acc_d = sum;
      end
      if (last_sample) begin
        samp_cnt_d = '0;
        if (last_bit) begin
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = shift_ins;
        end
      end else begin
        samp_cnt_d = samp_cnt_q + 1'b1;
      end
    end

    if (word_done && (!word_valid_q || drain)) begin
      word_d       = shift_ins;
      word_valid_d = 1'b1;
    end else if (word_done) begin
      pend_d = shift_ins;
      if (state_q == StWait) overrun_d = 1'b1;
    end else if ((state_q == StWait) && drain) begin
      word_d       = pend_q;
      word_valid_d = 1'b1;
    end else if (drain) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q        <= 1'b0;
      acc_q        <= '0;
      thr_q        <= '0;
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      pend_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      acc_q        <= acc_d;
      thr_q        <= thr_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_demod_integrate_pack.sv
// Bench for demod_integrate_pack: directed and random samples scored against an arithmetic
// model of integrate, threshold and LSB-first packing.
module tb_demod_integrate_pack;

  localparam int SPB = 4;
  localparam int BPW = 8;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] demodulated_in;
  logic [31:0] a_in;
  logic        sync_clear;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  longint      m_sum;
  longint      m_thr;
  int          m_cnt;
  int          m_bitn;
  logic [31:0] m_word;
  logic [31:0] exp_q[$];

  demod_integrate_pack #(
    .SAMPLES_PER_BIT(SPB),
    .BITS_PER_WORD  (BPW),
    .ACC_W          (34)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .demodulated_in(demodulated_in),
    .a_in          (a_in),
    .sync_clear    (sync_clear),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    m_sum  = 0;
    m_cnt  = 0;
    m_bitn = 0;
    m_word = '0;
  endfunction

  function automatic void model_feed(input logic [31:0] d, input logic [31:0] a);
    longint sd;
    sd = longint'($signed(d));
    if (m_cnt == 0) begin
      m_sum = sd;
      m_thr = longint'($signed(a));
    end else begin
      m_sum += sd;
    end
    m_cnt++;
    if (m_cnt == SPB) begin
      m_cnt = 0;
      if (m_sum > m_thr) m_word[m_bitn] = 1'b1;
      m_bitn++;
      if (m_bitn == BPW) begin
        exp_q.push_back(m_word);
        m_word = '0;
        m_bitn = 0;
      end
    end
  endfunction

  function automatic logic [31:0] rnd_d();
    if ($urandom_range(0, 1) == 1) return $urandom;
    return 32'($signed($urandom_range(0, 200)) - 100);
  endfunction

  function automatic logic [31:0] rnd_a();
    return 32'($signed($urandom_range(0, 2000)) - 1000);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the sample is taken.
  task automatic send(input logic [31:0] d, input logic [31:0] a, input bit clr, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid       = 1'b1;
    demodulated_in = d;
    a_in           = a;
    sync_clear     = clr;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    if (in_ready) begin
      if (clr) model_clear();
      else model_feed(d, a);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    sync_clear = 1'b0;
  endtask

  task automatic send_bit(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] d3, input logic [31:0] a0, input logic [31:0] ar);
    send(d0, a0, 1'b0, 0);
    send(d1, ar, 1'b0, 0);
    send(d2, ar, 1'b0, 0);
    send(d3, ar, 1'b0, 0);
  endtask

  task automatic send_rand(input int count);
    for (int i = 0; i < count; i++) send(rnd_d(), rnd_a(), 1'b0, int'($urandom_range(0, 1)));
  endtask

  // Scoreboard: every transfer must match the next word the model produced.
  always @(negedge clk) begin
    if (reset && word_valid && word_ready) begin
      chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("word_stream", word_out, exp_q.pop_front());
    end
  end

  initial begin
    logic [31:0] held;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          n;

    reset          = 1'b0;
    in_valid       = 1'b0;
    demodulated_in = '0;
    a_in           = '0;
    sync_clear     = 1'b0;
    word_ready     = 1'b0;
    model_clear();
    m_thr = 0;

    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_word_valid", word_valid, 1'b0);
    chk("rst_word_out", word_out, 32'h0);
    chk("rst_overrun", overrun, 1'b0);
    #20 reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Slicing and packing: bits 1,0,1,1,0,0,0,1
    word_ready = 1'b1;
    send_bit(32'd5, 32'd5, -32'sd3, -32'sd3, 32'd0, 32'd0);
    send_bit(32'd1, -32'sd1, 32'd2, -32'sd2, 32'd0, 32'd0);
    send_bit(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0);
    send_bit(32'd5, 32'd5, -32'sd3, -32'sd3, 32'd0, 32'd0);
    send_bit(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
    send_bit(32'd20, 32'd10, 32'd10, 32'd10, 32'd100, -32'sd1000);
    send_bit(32'd1, -32'sd1, 32'd2, -32'sd2, 32'd0, 32'd0);
    chk("pack_before_last", word_valid, 1'b0);
    send_bit(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0);
    @(negedge clk);
    chk("pack_valid", word_valid, 1'b1);
    chk("pack_word", word_out, 32'h0000_008D);
    @(negedge clk);
    chk("pack_valid_fall", word_valid, 1'b0);
    @(posedge clk);
    #1;

    // Back-pressure: two words with the consumer stalled
    word_ready = 1'b0;
    send_rand(2 * BPW * SPB);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_valid", word_valid, 1'b1);
    chk("bp_queued", 64'(exp_q.size()), 64'd2);
    exp_a = exp_q[0];
    exp_b = exp_q[1];
    chk("bp_first_held", word_out, exp_a);
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_out", word_out, exp_a);
    @(negedge clk);
    chk("bp_second_valid", word_valid, 1'b1);
    chk("bp_second_out", word_out, exp_b);
    chk("bp_in_ready_back", in_ready, 1'b1);
    @(negedge clk);
    chk("bp_drained", word_valid, 1'b0);
    chk("bp_overrun", overrun, 1'b0);
    @(posedge clk);
    #1;

    // sync_clear with a queued word
    word_ready = 1'b0;
    send_rand(BPW * SPB);
    held = word_out;
    chk("sc_held_valid", word_valid, 1'b1);
    send_rand(2 * SPB + 3);
    send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);
    @(negedge clk);
    chk("sc_word_kept", word_out, held);
    chk("sc_valid_kept", word_valid, 1'b1);
    @(posedge clk);
    #1;
    send_rand(BPW * SPB);
    @(negedge clk);
    chk("sc_wait_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("sc_all_out", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Random consumer stalls across several words
    for (int i = 0; i < 3 * BPW * SPB; i++) begin
      word_ready = 1'($urandom_range(0, 1));
      send(rnd_d(), rnd_a(), 1'b0, int'($urandom_range(0, 1)));
    end
    word_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rnd_all_out", 64'(exp_q.size()), 64'd0);
    chk("rnd_overrun", overrun, 1'b0);
    @(posedge clk);
    #1;

    // Reset mid-word with a word held on the output
    word_ready = 1'b0;
    send_rand(BPW * SPB + 10);
    chk("mr_valid_before", word_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mr_valid", word_valid, 1'b0);
    chk("mr_word", word_out, 32'h0);
    chk("mr_in_ready", in_ready, 1'b0);
    exp_q.delete();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    send_rand(BPW * SPB - 1);
    send(rnd_d(), rnd_a(), 1'b0, 0);
    n = 0;
    @(negedge clk);
    while (!word_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mr_new_word_valid", word_valid, 1'b1);
    @(negedge clk);
    chk("mr_all_out", 64'(exp_q.size()), 64'd0);
    chk("mr_overrun", overrun, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demod_integrate_pack.md
Name: demod_integrate_pack

Overview:
- Downstream consumer of the demodulation if/else combine stage.
- Takes the selected demodulated sample (demodulated_out_1_combine) and the selected amplitude term (a_combine) one sample per cycle.
- Integrates SAMPLES_PER_BIT samples per bit (integrate-and-dump) and slices each bit against the captured amplitude threshold.
- Packs BITS_PER_WORD decided bits LSB-first into a word and hands the word out on a valid/ready interface, with one level of back-pressure buffering.

Parameters:
- SAMPLES_PER_BIT, 8, samples integrated per decided bit (>=2).
- BITS_PER_WORD, 32, bits packed per output word (1..32; unused upper bits are 0).
- ACC_W, 35, accumulator width; must be >= 32+clog2(SAMPLES_PER_BIT) so the accumulator never overflows.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  demodulated_in/a_in carry a sample this cycle.
- in_ready  output  1  block accepts the sample this cycle; a sample is taken when in_valid&in_ready.
- demodulated_in  input  32  signed two's-complement sample (from demodulated_out_1_combine).
- a_in  input  32  signed amplitude threshold term (from a_combine).
- sync_clear  input  1  synchronous flush of the partial bit and partial word.
- word_out  output  32  packed bits, bit0 = first decided bit.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer takes word_out when word_valid&word_ready.
- overrun  output  1  sticky flag: a word completed while both the output register and the pending register were busy (must never occur under the handshake; diagnostic only).

Behaviour:
- Reset (reset=0, asynchronous) clears: accumulator, sample counter, bit counter, shift register, pending register, threshold register, state=ACCUM. Outputs go to in_ready=0 while reset is asserted, then 1 on the first cycle after release; word_out=0, word_valid=0, overrun=0.
- State ACCUM, in_ready=1:
  - On the accepted sample with sample counter=0: acc <= sign-extended demodulated_in, and thr <= sign-extended a_in.
  - On any other accepted sample: acc <= acc + demodulated_in.
  - Sample counter wraps at SAMPLES_PER_BIT-1.
- Bit decision on the accepted sample with sample counter=SAMPLES_PER_BIT-1:
  - Compute sum = acc + demodulated_in.
  - bit = (sum > thr), as a signed compare, thr sign-extended to ACC_W.
  - The bit is inserted at position bit counter of the shift register.
  - The bit counter increments and wraps at BITS_PER_WORD-1.
- Word completion on the decision cycle where bit counter=BITS_PER_WORD-1:
  - If the output register is empty, or is drained this same cycle (word_valid&word_ready): word_out <= completed word, word_valid=1 next cycle. Latency from the final accepted sample to word_valid is 1 cycle.
  - Else: the completed word goes to the pending register, state -> WAIT.
  - The shift register clears for the next word in both cases.
- State WAIT:
  - in_ready=0; no samples are accepted.
  - When word_valid&word_ready: word_out <= pending word, word_valid stays 1, state -> ACCUM, and in_ready=1 from the next cycle.
- Output handshake:
  - word_out and word_valid hold stable while word_valid=1 and word_ready=0.
  - On word_valid&word_ready with no new word arriving, word_valid falls next cycle.
  - word_ready is ignored while word_valid=0.
- Simultaneous events:
  - Drain and completion in the same cycle: the new word is loaded directly and word_valid stays high, with no bubble.
  - sync_clear together with an accepted sample: sync_clear wins. acc, sample counter, bit counter and shift register clear, and the sample is discarded.
  - sync_clear never touches word_out, word_valid or the pending register. In WAIT it is ignored.
- Arithmetic: all sums are signed at ACC_W bits; no saturation is required because ACC_W is sized to avoid overflow. Equality (sum==thr) decides 0.
- in_valid=0 gaps: all state holds; gaps inside a bit period do not affect the result.

Test Plan:
- Reset mid-word (SAMPLES_PER_BIT=4, BITS_PER_WORD=8): feed 10 samples, pulse reset low asynchronously between edges -> word_valid=0, word_out=0 immediately; the next 32 samples produce one clean word.
- Bit slicing: a_in=0, samples +5,+5,-3,-3 (sum 4) -> bit 1; samples +1,-1,+2,-2 (sum 0) -> bit 0; samples 0x7FFFFFFF x4 -> bit 1 with no overflow; samples 0x80000000 x4 -> bit 0.
- Packing: 8 bits decided in the order 1,0,1,1,0,0,0,1 with word_ready=1 -> word_out=0x0000008D, word_valid high exactly 1 cycle, 1 cycle after the final sample.
- Back-pressure: word_ready=0, stream 2 full words -> first word held on word_out; after the second word completes, in_ready=0. Raise word_ready -> first word consumed, then second presented next cycle with no bubble, and in_ready=1 again; overrun stays 0.
- sync_clear: after 3 of 4 samples of bit 2, assert sync_clear together with a valid sample -> that sample is dropped and the next word starts at bit0; a previously queued word_out is unchanged.
- Threshold capture: a_in=100 on the first sample and a_in=-1000 on the others, sum=50 -> bit 0 (threshold taken from the first sample only).
